// File: rtl/dffram_pkg.sv
// -----------------------------------------------------------------------------
// dffram_pkg
// Shared definitions for the two-port DFFRAM arbiter:
//   - WORDS_DEFAULT : number of populated RAM words (default address limit)
//   - arb_state_e   : ownership FSM encoding (FREE, OWN0, OWN1)
//   - rsp_t         : response-stage register contents (one access in flight)
// -----------------------------------------------------------------------------
package dffram_pkg;

    // Populated words in the default macro; addresses at or above this are
    // treated as out of range and never reach the RAM.
    localparam int WORDS_DEFAULT = 5120;

    // FREE : arbitration open to both ports.
    // OWNn : port n holds the RAM (locked); the other port is held off.
    typedef enum logic [1:0] {
        FREE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } arb_state_e;

    // Response stage: captured in the grant cycle, drives ACK/ERR/DO the
    // following cycle.
    typedef struct packed {
        logic valid;  // an access was granted last cycle
        logic port;   // 0 = port 0, 1 = port 1
        logic err;    // address was out of range
        logic rd;     // access was a read (all byte enables low)
    } rsp_t;

endpackage : dffram_pkg

// File: rtl/dffram_rr_pick.sv
// -----------------------------------------------------------------------------
// dffram_rr_pick
// Two-requester winner selection used while the arbiter is FREE.
//   RR != 0 : round-robin; on contention the port named by favour_i wins.
//   RR == 0 : fixed priority; port 0 wins whenever it requests.
// A lone requester always wins immediately.
//
// Ports
//   req_i    [1:0]  request vector, bit n = port n
//   favour_i        port favoured on contention (round-robin mode only)
//   gnt_o    [1:0]  one-hot (or zero) winner
// -----------------------------------------------------------------------------
module dffram_rr_pick #(
    parameter int RR = 1
) (
    input  logic [1:0] req_i,
    input  logic       favour_i,
    output logic [1:0] gnt_o
);

    always_comb begin
        // NOTE: assign every combinational output a default first so no path
        // leaves it unassigned -- otherwise synthesis infers a latch.
        gnt_o = 2'b00;
        if (req_i == 2'b11) begin
            if ((RR != 0) && favour_i) begin
                gnt_o = 2'b10;
            end else begin
                gnt_o = 2'b01;
            end
        end else begin
            // Zero or one requester: the request vector is already the grant.
            gnt_o = req_i;
        end
    end

endmodule : dffram_rr_pick

// File: rtl/dffram_arbiter.sv
// -----------------------------------------------------------------------------
// dffram_arbiter
// Arbitrates two requesters onto one single-ported DFFRAM with one access per
// cycle. Grants are combinational in the request cycle; the RAM sees the
// winner's address/data in that same cycle, and the winner receives a one-cycle
// ACK (with ERR and read data) on the following cycle. A requester may LOCK
// the RAM across accesses, parking the FSM in OWNn until it releases.
//
// Parameters
//   AW     word-address width
//   WORDS  populated words; addresses >= WORDS complete with ERR, no RAM access
//   RR     1 = round-robin on contention, 0 = fixed priority (port 0 first)
//
// Ports (n = 0, 1)
//   clk, rst_n            clock, asynchronous active-low reset
//   pn_req                port n presents an access this cycle
//   pn_we   [3:0]         byte write enables, all-zero = read
//   pn_a    [AW-1:0]      word address
//   pn_di   [31:0]        write data
//   pn_lock               keep ownership after this access
//   pn_gnt                access accepted this cycle (combinational)
//   pn_ack                completion pulse, one cycle after grant
//   pn_err                qualifies ack: access was out of range
//   pn_do   [31:0]        read data on ack of an in-range read, else 0
//   ram_en/we/a/di        RAM request, driven in the grant cycle
//   ram_do  [31:0]        RAM read data, one cycle after ram_en
// -----------------------------------------------------------------------------
module dffram_arbiter
    import dffram_pkg::*;
#(
    parameter int AW    = 13,
    parameter int WORDS = WORDS_DEFAULT,
    parameter int RR    = 1
) (
    input  logic          clk,
    input  logic          rst_n,

    input  logic          p0_req,
    input  logic [3:0]    p0_we,
    input  logic [AW-1:0] p0_a,
    input  logic [31:0]   p0_di,
    input  logic          p0_lock,
    output logic          p0_gnt,
    output logic          p0_ack,
    output logic          p0_err,
    output logic [31:0]   p0_do,

    input  logic          p1_req,
    input  logic [3:0]    p1_we,
    input  logic [AW-1:0] p1_a,
    input  logic [31:0]   p1_di,
    input  logic          p1_lock,
    output logic          p1_gnt,
    output logic          p1_ack,
    output logic          p1_err,
    output logic [31:0]   p1_do,

    output logic          ram_en,
    output logic [3:0]    ram_we,
    output logic [AW-1:0] ram_a,
    output logic [31:0]   ram_di,
    input  logic [31:0]   ram_do
);

    localparam logic [31:0] WORDS_U = 32'(WORDS);

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    arb_state_e state_q, state_d;
    logic       favour_q, favour_d;   // port that wins the next FREE contention
    rsp_t       rsp_q, rsp_d;

    // -------------------------------------------------------------------------
    // Grant selection
    // -------------------------------------------------------------------------
    logic [1:0] pick;
    logic [1:0] gnt;
    logic       any_gnt;
    logic       win;                  // winning port when any_gnt
    logic [AW-1:0] win_a;
    logic [3:0]    win_we;
    logic [31:0]   win_di;
    logic          win_lock;
    logic          in_range;

    dffram_rr_pick #(
        .RR (RR)
    ) u_pick (
        .req_i    ({p1_req, p0_req}),
        .favour_i (favour_q),
        .gnt_o    (pick)
    );

    always_comb begin
        gnt = 2'b00;
        case (state_q)
            FREE:    gnt = pick;
            OWN0:    gnt = {1'b0, p0_req};
            OWN1:    gnt = {p1_req, 1'b0};
            default: gnt = 2'b00;
        endcase
        // No grant while reset is held, so nothing reaches the RAM and no
        // response can be captured when reset releases.
        if (!rst_n) begin
            gnt = 2'b00;
        end
    end

    assign any_gnt  = |gnt;
    assign win      = gnt[1];
    assign win_a    = win ? p1_a    : p0_a;
    assign win_we   = win ? p1_we   : p0_we;
    assign win_di   = win ? p1_di   : p0_di;
    assign win_lock = win ? p1_lock : p0_lock;
    assign in_range = 32'(win_a) < WORDS_U;

    assign p0_gnt = gnt[0];
    assign p1_gnt = gnt[1];

    // -------------------------------------------------------------------------
    // RAM request: address/data follow the winner; enable and write strobes
    // only for an in-range grant.
    // -------------------------------------------------------------------------
    assign ram_en = any_gnt && in_range;
    assign ram_we = ram_en ? win_we : 4'b0000;
    assign ram_a  = win_a;
    assign ram_di = win_di;

    // -------------------------------------------------------------------------
    // Ownership FSM and round-robin pointer
    // -------------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        favour_d = favour_q;
        case (state_q)
            FREE: begin
                if (any_gnt) begin
                    // Pointer moves only on FREE grants: favour the loser.
                    favour_d = ~win;
                    if (win_lock) begin
                        state_d = win ? OWN1 : OWN0;
                    end else begin
                        state_d = FREE;
                    end
                end
            end
            OWN0: begin
                // No grant in OWN0 means port 0 dropped its request.
                if (gnt[0] && p0_lock) begin
                    state_d = OWN0;
                end else begin
                    state_d = FREE;
                end
            end
            OWN1: begin
                if (gnt[1] && p1_lock) begin
                    state_d = OWN1;
                end else begin
                    state_d = FREE;
                end
            end
            default: state_d = FREE;
        endcase
    end

    // -------------------------------------------------------------------------
    // Response stage: capture the grant, present it next cycle.
    // -------------------------------------------------------------------------
    always_comb begin
        rsp_d.valid = any_gnt;
        rsp_d.port  = win;
        rsp_d.err   = any_gnt && !in_range;
        rsp_d.rd    = (win_we == 4'b0000);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= FREE;
            favour_q <= 1'b0;
            rsp_q    <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples pre-edge values, independent of statement order.
            state_q  <= state_d;
            favour_q <= favour_d;
            rsp_q    <= rsp_d;
        end
    end

    // -------------------------------------------------------------------------
    // Per-port completion outputs
    // -------------------------------------------------------------------------
    logic ack0, ack1;
    logic rd_data_ok;

    assign ack0       = rsp_q.valid && !rsp_q.port;
    assign ack1       = rsp_q.valid &&  rsp_q.port;
    assign rd_data_ok = rsp_q.rd && !rsp_q.err;

    assign p0_ack = ack0;
    assign p1_ack = ack1;
    assign p0_err = ack0 && rsp_q.err;
    assign p1_err = ack1 && rsp_q.err;
    assign p0_do  = (ack0 && rd_data_ok) ? ram_do : 32'h0;
    assign p1_do  = (ack1 && rd_data_ok) ? ram_do : 32'h0;

endmodule : dffram_arbiter

// File: tb/tb_dffram_arbiter.sv
// -----------------------------------------------------------------------------
// tb_dffram_arbiter
// Two arbiters share one stimulus stream: index 0 is round-robin, index 1 is
// fixed priority. Each has its own behavioural RAM. A reference model (owner,
// favoured port, pending response, shadow memory) predicts every output each
// cycle; directed literal checks pin the key scenarios.
// -----------------------------------------------------------------------------
module tb_dffram_arbiter;

    localparam int AW    = 13;
    localparam int WORDS = 5120;
    localparam int DEPTH = 1 << AW;

    typedef struct packed {
        logic          req;
        logic [3:0]    we;
        logic [AW-1:0] a;
        logic [31:0]   di;
        logic          lock;
    } port_in_t;

    localparam port_in_t IDLE = '0;

    logic clk = 1'b0;
    logic rst_n;

    logic          p0_req, p1_req, p0_lock, p1_lock;
    logic [3:0]    p0_we, p1_we;
    logic [AW-1:0] p0_a, p1_a;
    logic [31:0]   p0_di, p1_di;

    // index 0 = round-robin instance, index 1 = fixed-priority instance
    logic [1:0]    p0_gnt, p1_gnt, p0_ack, p1_ack, p0_err, p1_err, ram_en;
    logic [31:0]   p0_do [2];
    logic [31:0]   p1_do [2];
    logic [31:0]   ram_di [2];
    logic [31:0]   ram_do [2];
    logic [3:0]    ram_we [2];
    logic [AW-1:0] ram_a [2];

    int n_cmp = 0;
    int n_mis = 0;

    always #5 clk = ~clk;

    dffram_arbiter #(.AW(AW), .WORDS(WORDS), .RR(1)) u_rr (
        .clk(clk), .rst_n(rst_n),
        .p0_req(p0_req), .p0_we(p0_we), .p0_a(p0_a), .p0_di(p0_di), .p0_lock(p0_lock),
        .p0_gnt(p0_gnt[0]), .p0_ack(p0_ack[0]), .p0_err(p0_err[0]), .p0_do(p0_do[0]),
        .p1_req(p1_req), .p1_we(p1_we), .p1_a(p1_a), .p1_di(p1_di), .p1_lock(p1_lock),
        .p1_gnt(p1_gnt[0]), .p1_ack(p1_ack[0]), .p1_err(p1_err[0]), .p1_do(p1_do[0]),
        .ram_en(ram_en[0]), .ram_we(ram_we[0]), .ram_a(ram_a[0]), .ram_di(ram_di[0]),
        .ram_do(ram_do[0])
    );

    dffram_arbiter #(.AW(AW), .WORDS(WORDS), .RR(0)) u_fp (
        .clk(clk), .rst_n(rst_n),
        .p0_req(p0_req), .p0_we(p0_we), .p0_a(p0_a), .p0_di(p0_di), .p0_lock(p0_lock),
        .p0_gnt(p0_gnt[1]), .p0_ack(p0_ack[1]), .p0_err(p0_err[1]), .p0_do(p0_do[1]),
        .p1_req(p1_req), .p1_we(p1_we), .p1_a(p1_a), .p1_di(p1_di), .p1_lock(p1_lock),
        .p1_gnt(p1_gnt[1]), .p1_ack(p1_ack[1]), .p1_err(p1_err[1]), .p1_do(p1_do[1]),
        .ram_en(ram_en[1]), .ram_we(ram_we[1]), .ram_a(ram_a[1]), .ram_di(ram_di[1]),
        .ram_do(ram_do[1])
    );

    // -------------------------------------------------------------------------
    // Behavioural RAMs (environment): registered read, byte-enabled write.
    // -------------------------------------------------------------------------
    function automatic logic [31:0] init_word(input int a);
        return 32'hA5A5_0000 + 32'(a);
    endfunction

    logic [31:0] env_mem [2][DEPTH];

    initial begin
        for (int k = 0; k < 2; k++)
            for (int i = 0; i < DEPTH; i++)
                env_mem[k][i] = init_word(i);
    end

    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (ram_en[k]) begin
                ram_do[k] <= env_mem[k][ram_a[k]];
                for (int b = 0; b < 4; b++)
                    if (ram_we[k][b])
                        env_mem[k][ram_a[k]][8*b +: 8] <= ram_di[k][8*b +: 8];
            end
        end
    end

    // -------------------------------------------------------------------------
    // Reference model state
    // -------------------------------------------------------------------------
    int          owner [2];           // -1 = nobody, else locked port
    bit          fav   [2];           // port that wins the next free contention
    bit          pv    [2];           // a response is due this cycle
    bit          pport [2];
    bit          perr  [2];
    logic [31:0] pdata [2];
    logic [31:0] mdl_mem [2][DEPTH];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic model_check();
        int            win;
        logic [AW-1:0] a;
        logic [3:0]    we;
        logic [31:0]   di;
        logic          lock;
        bit            inr;
        bit            e_ack0, e_ack1;
        string         t;
        for (int k = 0; k < 2; k++) begin
            t = (k == 0) ? "rr" : "fp";
            if (!rst_n) begin
                check({t, "_rst_gnt"},  32'({p1_gnt[k], p0_gnt[k]}), 0);
                check({t, "_rst_ack"},  32'({p1_ack[k], p0_ack[k]}), 0);
                check({t, "_rst_err"},  32'({p1_err[k], p0_err[k]}), 0);
                check({t, "_rst_en"},   32'(ram_en[k]), 0);
                check({t, "_rst_we"},   32'(ram_we[k]), 0);
                check({t, "_rst_do0"},  p0_do[k], 0);
                check({t, "_rst_do1"},  p1_do[k], 0);
                owner[k] = -1;
                fav[k]   = 1'b0;
                pv[k]    = 1'b0;
            end else begin
                // Response for last cycle's grant
                e_ack0 = pv[k] && !pport[k];
                e_ack1 = pv[k] &&  pport[k];
                check({t, "_ack"}, 32'({p1_ack[k], p0_ack[k]}), 32'({e_ack1, e_ack0}));
                check({t, "_err"}, 32'({p1_err[k], p0_err[k]}),
                      32'({e_ack1 && perr[k], e_ack0 && perr[k]}));
                check({t, "_do0"}, p0_do[k], e_ack0 ? pdata[k] : 32'h0);
                check({t, "_do1"}, p1_do[k], e_ack1 ? pdata[k] : 32'h0);

                // Who wins this cycle
                win = -1;
                if (owner[k] == 0) begin
                    if (p0_req) win = 0;
                end else if (owner[k] == 1) begin
                    if (p1_req) win = 1;
                end else if (p0_req && p1_req) begin
                    win = (k == 0) ? (fav[k] ? 1 : 0) : 0;
                end else if (p0_req) begin
                    win = 0;
                end else if (p1_req) begin
                    win = 1;
                end
                check({t, "_gnt"}, 32'({p1_gnt[k], p0_gnt[k]}), 32'({win == 1, win == 0}));

                if (win >= 0) begin
                    a    = (win == 1) ? p1_a    : p0_a;
                    we   = (win == 1) ? p1_we   : p0_we;
                    di   = (win == 1) ? p1_di   : p0_di;
                    lock = (win == 1) ? p1_lock : p0_lock;
                    inr  = int'(a) < WORDS;
                    check({t, "_ram_en"}, 32'(ram_en[k]), 32'(inr));
                    check({t, "_ram_we"}, 32'(ram_we[k]), inr ? 32'(we) : 32'h0);
                    check({t, "_ram_a"},  32'(ram_a[k]),  32'(a));
                    check({t, "_ram_di"}, ram_di[k], di);
                    pv[k]    = 1'b1;
                    pport[k] = (win == 1);
                    perr[k]  = !inr;
                    pdata[k] = (inr && we == 4'h0) ? mdl_mem[k][a] : 32'h0;
                    if (inr)
                        for (int b = 0; b < 4; b++)
                            if (we[b]) mdl_mem[k][a][8*b +: 8] = di[8*b +: 8];
                    if (owner[k] < 0) fav[k] = (win == 0);
                    owner[k] = lock ? win : -1;
                end else begin
                    check({t, "_idle_en"}, 32'(ram_en[k]), 0);
                    check({t, "_idle_we"}, 32'(ram_we[k]), 0);
                    pv[k]    = 1'b0;
                    owner[k] = -1;
                end
            end
        end
    endtask

    // One clock cycle: drive just after the rising edge, check at the falling edge.
    task automatic step(input logic rst, input port_in_t a, input port_in_t b);
        @(posedge clk);
        #1;
        rst_n   = rst;
        p0_req  = a.req;  p0_we = a.we;  p0_a = a.a;  p0_di = a.di;  p0_lock = a.lock;
        p1_req  = b.req;  p1_we = b.we;  p1_a = b.a;  p1_di = b.di;  p1_lock = b.lock;
        @(negedge clk);
        model_check();
    endtask

    function automatic port_in_t acc(input logic [AW-1:0] a, input logic [3:0] we,
                                     input logic [31:0] di, input logic lock);
        port_in_t p;
        p.req = 1'b1; p.we = we; p.a = a; p.di = di; p.lock = lock;
        return p;
    endfunction

    // -------------------------------------------------------------------------
    // Directed scenarios
    // -------------------------------------------------------------------------
    initial begin
        rst_n  = 1'b0;
        p0_req = 1'b0; p0_we = 4'h0; p0_a = '0; p0_di = 32'h0; p0_lock = 1'b0;
        p1_req = 1'b0; p1_we = 4'h0; p1_a = '0; p1_di = 32'h0; p1_lock = 1'b0;
        for (int k = 0; k < 2; k++) begin
            owner[k] = -1; fav[k] = 1'b0; pv[k] = 1'b0;
            pport[k] = 1'b0; perr[k] = 1'b0; pdata[k] = 32'h0;
            for (int i = 0; i < DEPTH; i++) mdl_mem[k][i] = init_word(i);
        end

        // Requests during reset are ignored
        step(1'b0, acc(13'h005, 4'h0, 32'h0, 1'b0), acc(13'h006, 4'h0, 32'h0, 1'b0));
        check("rst_p0_gnt", 32'(p0_gnt), 0);
        check("rst_ram_en", 32'(ram_en), 0);
        step(1'b0, acc(13'h005, 4'h0, 32'h0, 1'b0), IDLE);

        // Single read from port 0
        step(1'b1, acc(13'h005, 4'h0, 32'h0, 1'b0), IDLE);
        check("rd_gnt", 32'(p0_gnt[0]), 1);
        check("rd_en",  32'(ram_en[0]), 1);
        check("rd_a",   32'(ram_a[0]), 32'h005);
        step(1'b1, IDLE, IDLE);
        check("rd_ack", 32'(p0_ack[0]), 1);
        check("rd_do",  p0_do[0], 32'hA5A5_0005);
        check("rd_do1", p1_do[0], 32'h0);

        // Out-of-range write from port 1 (first address past the populated words)
        step(1'b1, IDLE, acc(13'h1400, 4'hF, 32'hDEAD_BEEF, 1'b0));
        check("oor_gnt", 32'(p1_gnt), 32'b11);
        check("oor_en",  32'(ram_en), 0);
        check("oor_we",  32'(ram_we[0]), 0);
        step(1'b1, IDLE, IDLE);
        check("oor_ack", 32'(p1_ack[0]), 1);
        check("oor_err", 32'(p1_err[0]), 1);
        check("oor_do",  p1_do[0], 32'h0);

        // Last populated word: write then read back-to-back
        step(1'b1, acc(13'h13FF, 4'hF, 32'hCAFE_F00D, 1'b0), IDLE);
        check("top_en", 32'(ram_en[0]), 1);
        step(1'b1, acc(13'h13FF, 4'h0, 32'h0, 1'b0), IDLE);
        check("top_wack", 32'(p0_ack[0]), 1);
        check("top_wdo",  p0_do[0], 32'h0);
        step(1'b1, IDLE, IDLE);
        check("top_rdo",  p0_do[0], 32'hCAFE_F00D);

        // Point round-robin at port 0, then contend for 4 cycles
        step(1'b1, IDLE, acc(13'h002, 4'h0, 32'h0, 1'b0));
        for (int i = 0; i < 4; i++) begin
            step(1'b1, acc(13'h001, 4'h0, 32'h0, 1'b0), acc(13'h002, 4'h0, 32'h0, 1'b0));
            check($sformatf("rr_g0_%0d", i), 32'(p0_gnt[0]), 32'(i % 2 == 0));
            check($sformatf("rr_g1_%0d", i), 32'(p1_gnt[0]), 32'(i % 2 == 1));
            check($sformatf("fp_g0_%0d", i), 32'(p0_gnt[1]), 1);
            check($sformatf("fp_g1_%0d", i), 32'(p1_gnt[1]), 0);
            check($sformatf("rr_ack1_%0d", i), 32'(p1_ack[0]), 32'(i == 0 || i == 2));
        end
        step(1'b1, IDLE, IDLE);
        check("rr_last_ack1", 32'(p1_ack[0]), 1);
        check("rr_last_do1",  p1_do[0], 32'hA5A5_0002);

        // Partial write, read back, then an out-of-range read
        step(1'b1, acc(13'h003, 4'b0101, 32'h1234_5678, 1'b0), IDLE);
        step(1'b1, acc(13'h003, 4'h0, 32'h0, 1'b0), IDLE);
        step(1'b1, acc(13'h1FFF, 4'h0, 32'h0, 1'b0), IDLE);
        check("bwe_do_rr", p0_do[0], 32'hA534_0078);
        check("bwe_do_fp", p0_do[1], 32'hA534_0078);
        step(1'b1, IDLE, IDLE);
        check("oor_rd_err", 32'(p0_err[0]), 1);
        check("oor_rd_do",  p0_do[0], 32'h0);

        // Port 0 locks for 3 accesses while port 1 waits
        step(1'b1, IDLE, acc(13'h004, 4'h0, 32'h0, 1'b0));
        for (int i = 0; i < 3; i++) begin
            step(1'b1, acc(13'h007, 4'h0, 32'h0, 1'b1), acc(13'h008, 4'h0, 32'h0, 1'b0));
            check($sformatf("lk_g0_%0d", i), 32'(p0_gnt), 32'b11);
            check($sformatf("lk_g1_%0d", i), 32'(p1_gnt), 0);
        end
        step(1'b1, IDLE, acc(13'h008, 4'h0, 32'h0, 1'b0));
        check("lk_drop_g1", 32'(p1_gnt), 0);
        step(1'b1, IDLE, acc(13'h008, 4'h0, 32'h0, 1'b0));
        check("lk_after_g1", 32'(p1_gnt), 32'b11);

        // Port 1 lock interrupted by reset
        step(1'b1, IDLE, acc(13'h009, 4'h0, 32'h0, 1'b1));
        step(1'b1, acc(13'h00A, 4'h0, 32'h0, 1'b0), acc(13'h009, 4'h0, 32'h0, 1'b1));
        check("own1_g1", 32'(p1_gnt), 32'b11);
        step(1'b0, acc(13'h00A, 4'h0, 32'h0, 1'b0), acc(13'h009, 4'h0, 32'h0, 1'b1));
        check("rst_ack_clr", 32'(p1_ack), 0);
        step(1'b1, acc(13'h00A, 4'h0, 32'h0, 1'b0), acc(13'h009, 4'h0, 32'h0, 1'b0));
        check("post_rst_g0", 32'(p0_gnt), 32'b11);
        check("post_rst_ack", 32'({p1_ack, p0_ack}), 0);
        step(1'b1, IDLE, IDLE);
        check("post_rst_ack0", 32'(p0_ack), 32'b11);

        // Port 1 lock released with LOCK=0 on its final access
        step(1'b1, IDLE, acc(13'h00B, 4'h0, 32'h0, 1'b1));
        step(1'b1, acc(13'h00C, 4'h0, 32'h0, 1'b0), acc(13'h00B, 4'h0, 32'h0, 1'b0));
        check("rel_g1", 32'(p1_gnt), 32'b11);
        step(1'b1, acc(13'h00C, 4'h0, 32'h0, 1'b0), acc(13'h00B, 4'h0, 32'h0, 1'b0));
        check("rel_g0", 32'(p0_gnt), 32'b11);
        step(1'b1, IDLE, IDLE);
        step(1'b1, IDLE, IDLE);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule : tb_dffram_arbiter
